// File: rtl/ysyx_22040759_pkg.sv
// Shared definitions for the ysyx_22040759 core sequencer: state encoding,
// halt cause codes and the fixed instruction words the sequencer inspects.
package ysyx_22040759_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_EBREAK  = 2'b01,
    CAUSE_ILLEGAL = 2'b10
  } halt_cause_t;

endpackage

// File: rtl/ysyx_22040759_perf_cnt.sv
// Cycle and retired-instruction counters for the core sequencer.
// Present only when YSYX_22040759_PERF_CNT_EN is defined; both counters
// are 64 bits wide and wrap naturally.
`ifdef YSYX_22040759_PERF_CNT_EN
module ysyx_22040759_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cycle_en,
  input  logic        instret_en,
  output logic [63:0] cycle_o,
  output logic [63:0] instret_o
);

  // Count running cycles and committed instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_o   <= 64'd0;
      instret_o <= 64'd0;
    end else begin
      if (cycle_en)   cycle_o   <= cycle_o + 64'd1;
      if (instret_en) instret_o <= instret_o + 64'd1;
    end
  end

endmodule
`endif

// File: rtl/ysyx_22040759_core_seq.sv
// Multi-cycle sequencer for the ysyx_22040759 RV32 core.
// Owns the PC, runs the fetch handshake, holds the fetched instruction for
// the decoder and allows exactly one register-file write / PC update per
// instruction. Halts on ebreak or an instruction the decoder rejects.
// Optional: define YSYX_22040759_PERF_CNT_EN to add perf_cycle_o and
// perf_instret_o counters.
module ysyx_22040759_core_seq
  import ysyx_22040759_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_addr,
  input  logic            if_resp_valid,
  input  logic [31:0]     if_rdata,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            dec_reg_wen,
  input  logic            dec_pc_sel,
  input  logic            dec_illegal,
  input  logic [XLEN-1:0] alu_result,
  output logic            rf_wen_o,
  output logic            halt_o,
  output logic [1:0]      halt_cause_o
`ifdef YSYX_22040759_PERF_CNT_EN
  ,
  output logic [63:0]     perf_cycle_o,
  output logic [63:0]     perf_instret_o
`endif
);

  seq_state_t state;
  logic       outstanding;

  // Jump targets are always halfword aligned; bit 0 of the ALU result is dropped.
  logic unused_alu_lsb;
  assign unused_alu_lsb = alu_result[0];

  assign if_addr = pc_o;

  // Main sequencer: state, PC, instruction latch and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here, including the instruction latch, has a
      // defined reset value so the decoder sees a nop, never X, after reset.
      state        <= ST_FETCH;
      pc_o         <= RESET_PC;
      inst_o       <= INST_NOP;
      if_req_valid <= 1'b0;
      rf_wen_o     <= 1'b0;
      halt_o       <= 1'b0;
      halt_cause_o <= CAUSE_NONE;
      outstanding  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the write strobe defaults
      // low and is raised only on entry to COMMIT, so it lasts one cycle.
      rf_wen_o <= 1'b0;
      unique case (state)
        ST_FETCH: begin
          if (!if_req_valid) begin
            // Only reached in the first cycle after reset.
            if_req_valid <= 1'b1;
          end else if (if_req_ready) begin
            if_req_valid <= 1'b0;
            outstanding  <= 1'b1;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (if_resp_valid && outstanding) begin
            inst_o      <= if_rdata;
            outstanding <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (inst_o == INST_EBREAK) begin
            state        <= ST_HALT;
            halt_o       <= 1'b1;
            halt_cause_o <= CAUSE_EBREAK;
          end else if (dec_illegal) begin
            state        <= ST_HALT;
            halt_o       <= 1'b1;
            halt_cause_o <= CAUSE_ILLEGAL;
          end else begin
            state    <= ST_COMMIT;
            rf_wen_o <= dec_reg_wen;
          end
        end
        ST_COMMIT: begin
          pc_o         <= dec_pc_sel ? {alu_result[XLEN-1:1], 1'b0}
                                     : pc_o + XLEN'(4);
          if_req_valid <= 1'b1;
          state        <= ST_FETCH;
        end
        ST_HALT: begin
          // Terminal until reset.
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

`ifdef YSYX_22040759_PERF_CNT_EN
  ysyx_22040759_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .cycle_en   (state != ST_HALT),
    .instret_en (state == ST_COMMIT),
    .cycle_o    (perf_cycle_o),
    .instret_o  (perf_instret_o)
  );
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_ysyx_22040759_core_seq.sv
// Self-checking bench for ysyx_22040759_core_seq. A transaction-level model
// tracks which instruction is in flight and predicts outputs every cycle;
// directed scenarios add hand-computed literal expectations.
module tb_ysyx_22040759_core_seq;
  import ysyx_22040759_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid;
  logic        if_req_ready = 1'b0;
  logic [31:0] if_addr;
  logic        if_resp_valid = 1'b0;
  logic [31:0] if_rdata = 32'hDEAD_BEEF;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        dec_reg_wen = 1'b0;
  logic        dec_pc_sel = 1'b0;
  logic        dec_illegal = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic        rf_wen_o;
  logic        halt_o;
  logic [1:0]  halt_cause_o;
`ifdef YSYX_22040759_PERF_CNT_EN
  logic [63:0] perf_cycle_o;
  logic [63:0] perf_instret_o;
`endif

  ysyx_22040759_core_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_resp_valid (if_resp_valid),
    .if_rdata      (if_rdata),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .dec_reg_wen   (dec_reg_wen),
    .dec_pc_sel    (dec_pc_sel),
    .dec_illegal   (dec_illegal),
    .alu_result    (alu_result),
    .rf_wen_o      (rf_wen_o),
    .halt_o        (halt_o),
    .halt_cause_o  (halt_cause_o)
`ifdef YSYX_22040759_PERF_CNT_EN
    ,
    .perf_cycle_o  (perf_cycle_o),
    .perf_instret_o(perf_instret_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rf_pulse_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the specification says must be visible this cycle.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_bubble;     // first cycle after reset, request not yet raised
  logic        m_out;        // fetch accepted, waiting for data
  int          m_age;        // 1: instruction executing, 2: committing, 0: neither
  logic        m_halted;
  logic [1:0]  m_cause;
  logic [63:0] m_cycles;
  logic [63:0] m_instret;

  // Compare DUT against the model, then advance the model over the next edge.
  always @(negedge clk) begin
    logic exp_valid;
    if (!rst_n) begin
      check("rst_req_valid", {63'd0, if_req_valid}, 64'd0);
      check("rst_pc", {32'd0, pc_o}, 64'h8000_0000);
      check("rst_inst", {32'd0, inst_o}, 64'h13);
      check("rst_rf_wen", {63'd0, rf_wen_o}, 64'd0);
      check("rst_halt", {63'd0, halt_o}, 64'd0);
      check("rst_cause", {62'd0, halt_cause_o}, 64'd0);
`ifdef YSYX_22040759_PERF_CNT_EN
      check("rst_perf_cycle", perf_cycle_o, 64'd0);
      check("rst_perf_instret", perf_instret_o, 64'd0);
`endif
      m_pc = 32'h8000_0000; m_inst = 32'h0000_0013;
      m_bubble = 1'b1; m_out = 1'b0; m_age = 0; m_halted = 1'b0; m_cause = 2'b00;
      m_cycles = 64'd0; m_instret = 64'd0;
    end else begin
      exp_valid = !(m_halted || m_out || (m_age != 0) || m_bubble);
      check("req_valid", {63'd0, if_req_valid}, {63'd0, exp_valid});
      if (exp_valid) check("if_addr", {32'd0, if_addr}, {32'd0, m_pc});
      check("pc", {32'd0, pc_o}, {32'd0, m_pc});
      check("inst", {32'd0, inst_o}, {32'd0, m_inst});
      check("rf_wen", {63'd0, rf_wen_o}, {63'd0, (m_age == 2) && dec_reg_wen});
      check("halt", {63'd0, halt_o}, {63'd0, m_halted});
      check("cause", {62'd0, halt_cause_o}, {62'd0, m_cause});
`ifdef YSYX_22040759_PERF_CNT_EN
      check("perf_cycle", perf_cycle_o, m_cycles);
      check("perf_instret", perf_instret_o, m_instret);
`endif
      if (rf_wen_o) rf_pulse_cnt++;

      if (!m_halted) m_cycles = m_cycles + 64'd1;
      if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (exp_valid && if_req_ready) begin
        m_out = 1'b1;
      end else if (m_out && if_resp_valid) begin
        m_inst = if_rdata; m_out = 1'b0; m_age = 1;
      end else if (m_age == 1) begin
        if (m_inst == 32'h0010_0073) begin
          m_halted = 1'b1; m_cause = 2'b01; m_age = 0;
        end else if (dec_illegal) begin
          m_halted = 1'b1; m_cause = 2'b10; m_age = 0;
        end else begin
          m_age = 2;
        end
      end else if (m_age == 2) begin
        m_pc = dec_pc_sel ? (alu_result & 32'hFFFF_FFFE) : m_pc + 32'd4;
        m_age = 0;
        m_instret = m_instret + 64'd1;
      end
    end
  end

  // Wait (bounded) for a fetch request; phase is always just after a rising edge.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (if_req_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("fetch_timeout", 64'd0, 64'd1);
  endtask

  // Serve one instruction: present decoder outputs, accept the fetch after
  // rdy_dly stall cycles, respond rsp_dly cycles later, then let it retire.
  task automatic run_inst(input logic [31:0] word, input int rdy_dly, input int rsp_dly,
                          input logic wen, input logic sel, input logic ill,
                          input logic [31:0] alu);
    bit ok;
    dec_reg_wen = wen; dec_pc_sel = sel; dec_illegal = ill; alu_result = alu;
    wait_valid(ok);
    if (!ok) return;
    repeat (rdy_dly) begin @(posedge clk); #1; end
    if_req_ready = 1'b1;
    @(posedge clk); #1;
    if_req_ready = 1'b0;
    repeat (rsp_dly - 1) begin @(posedge clk); #1; end
    if_resp_valid = 1'b1; if_rdata = word;
    @(posedge clk); #1;
    if_resp_valid = 1'b0; if_rdata = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    bit ok;
    @(posedge clk); #1;
    do_reset();

    // Straight-line execution, stalls, jumps and PC wrap.
    run_inst(32'h0050_0093, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("addi_next_addr", {32'd0, if_addr}, 64'h8000_0004);
    check("addi_rf_pulses", rf_pulse_cnt, 64'd1);
    run_inst(32'h0050_0093, 3, 5, 1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_next_pc", {32'd0, pc_o}, 64'h8000_0008);
    run_inst(32'h1000_00EF, 0, 1, 1'b1, 1'b1, 1'b0, 32'h8000_0101);
    check("jal_target", {32'd0, if_addr}, 64'h8000_0100);
    check("jal_rf_pulses", rf_pulse_cnt, 64'd3);
    run_inst(32'h0000_006F, 1, 2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD);
    check("jump_top", {32'd0, pc_o}, 64'hFFFF_FFFC);
    run_inst(32'h0000_0013, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("pc_wrap", {32'd0, pc_o}, 64'h0);

    // Reset while a fetch is outstanding, then a stale response.
    wait_valid(ok);
    if_req_ready = 1'b1;
    @(posedge clk); #1;
    if_req_ready = 1'b0;
    do_reset();
    if_resp_valid = 1'b1; if_rdata = 32'h0010_0073;
    @(posedge clk); #1;
    if_resp_valid = 1'b0; if_rdata = 32'hDEAD_BEEF;
    check("stale_pc", {32'd0, pc_o}, 64'h8000_0000);
    check("stale_inst", {32'd0, inst_o}, 64'h13);
    wait_valid(ok);
    check("fresh_fetch_addr", {32'd0, if_addr}, 64'h8000_0000);
    run_inst(32'h0050_0093, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Illegal instruction halts with cause 10.
    run_inst(32'hFFFF_FFFF, 0, 1, 1'b1, 1'b0, 1'b1, 32'h0);
    repeat (8) begin @(posedge clk); #1; end
    check("illegal_halt", {63'd0, halt_o}, 64'd1);
    check("illegal_cause", {62'd0, halt_cause_o}, 64'h2);
    check("illegal_pc", {32'd0, pc_o}, 64'h8000_0004);

    // Three instructions then ebreak (decoder also flags illegal: ebreak wins).
    do_reset();
    base = rf_pulse_cnt;
    for (int i = 0; i < 3; i++) run_inst(32'h0050_0093, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0);
    run_inst(32'h0010_0073, 0, 1, 1'b1, 1'b0, 1'b1, 32'h0);
    repeat (10) begin @(posedge clk); #1; end
    check("ebreak_halt", {63'd0, halt_o}, 64'd1);
    check("ebreak_cause", {62'd0, halt_cause_o}, 64'h1);
    check("ebreak_pc", {32'd0, pc_o}, 64'h8000_000C);
    check("ebreak_rf_pulses", rf_pulse_cnt - base, 64'd3);
`ifdef YSYX_22040759_PERF_CNT_EN
    check("perf_instret_final", perf_instret_o, 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
